// File: rtl/wrr_burst_scheduler_if.sv
// rtl/wrr_burst_scheduler_if.sv - request/grant bundle between requesters and the burst scheduler
interface wrr_burst_scheduler_if #(
  parameter int WW = 4
);
  logic [3:0]      i_req;
  logic [4*WW-1:0] i_weight;
  logic            i_beat;
  logic [3:0]      o_grant;
  logic [1:0]      o_grant_id;
  logic            o_timeout;

  modport master (
    output i_req, i_weight, i_beat,
    input  o_grant, o_grant_id, o_timeout
  );

  modport slave (
    input  i_req, i_weight, i_beat,
    output o_grant, o_grant_id, o_timeout
  );
endinterface

// File: rtl/wrr_burst_scheduler.sv
// rtl/wrr_burst_scheduler.sv - weighted round-robin burst arbiter with idle-owner timeout
module wrr_burst_scheduler #(
  parameter int TIMEOUT = 16,
  parameter int WW      = 4
) (
  input logic                   clk,
  input logic                   i_rst,
  wrr_burst_scheduler_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state, state_nx;
  logic [3:0]    grant, grant_nx;
  logic [1:0]    grant_id, id_nx;
  logic          timeout_q, timeout_nx;
  logic [1:0]    ptr, ptr_nx;
  logic [WW-1:0] credit, credit_nx;
  logic [TW-1:0] timer, timer_nx;

  logic [WW-1:0] weight_arr [4];
  logic          found;
  logic [1:0]    pick;
  logic [1:0]    idx;
  logic          drop, done, expire;

  // Split the packed weight bus into one entry per requester.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      weight_arr[k] = bus.i_weight[k*WW +: WW];
    end
  end

  // Round-robin search: first requesting index starting at ptr, wrapping modulo 4.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && bus.i_req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Release causes while a burst is in progress; a dropped request suppresses the timeout flag.
  always_comb begin
    drop   = !bus.i_req[grant_id];
    done   = bus.i_beat && (credit <= WW'(1));
    expire = !bus.i_beat && (timer == TW'(TIMEOUT - 1));
  end

  // Next-state and next-output logic for the IDLE/ACTIVE controller.
  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    id_nx      = grant_id;
    timeout_nx = 1'b0;
    ptr_nx     = ptr;
    credit_nx  = credit;
    timer_nx   = timer;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx  = ACTIVE;
          grant_nx  = 4'b0001 << pick;
          id_nx     = pick;
          ptr_nx    = pick + 2'd1;
          credit_nx = (weight_arr[pick] == '0) ? WW'(1) : weight_arr[pick];
          timer_nx  = '0;
        end
      end
      ACTIVE: begin
        if (bus.i_beat) begin
          if (credit > WW'(1)) begin
            credit_nx = credit - WW'(1);
          end
          timer_nx = '0;
        end else if (!expire) begin
          timer_nx = timer + TW'(1);
        end
        if (drop || done || expire) begin
          state_nx   = IDLE;
          grant_nx   = 4'b0000;
          timeout_nx = expire && !drop;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = 4'b0000;
      end
    endcase
  end

  // State and output registers; reset forces IDLE and restarts the search at requester 0.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= IDLE;
      grant     <= 4'b0000;
      grant_id  <= 2'd0;
      timeout_q <= 1'b0;
      ptr       <= 2'd0;
      credit    <= '0;
      timer     <= '0;
    end else begin
      state     <= state_nx;
      grant     <= grant_nx;
      grant_id  <= id_nx;
      timeout_q <= timeout_nx;
      ptr       <= ptr_nx;
      credit    <= credit_nx;
      timer     <= timer_nx;
    end
  end

  assign bus.o_grant    = grant;
  assign bus.o_grant_id = grant_id;
  assign bus.o_timeout  = timeout_q;
endmodule

// File: tb/tb_wrr_burst_scheduler.sv
// tb/tb_wrr_burst_scheduler.sv - directed and randomized bench against a behavioural arbiter model
module tb_wrr_burst_scheduler;
  localparam int TIMEOUT = 16;
  localparam int WW      = 4;

  logic clk = 1'b0;
  logic i_rst;

  wrr_burst_scheduler_if #(.WW(WW)) bus();

  wrr_burst_scheduler #(.TIMEOUT(TIMEOUT), .WW(WW)) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: who owns the resource, beats left in the burst, consecutive idle-owner cycles.
  int m_owner = -1;
  int m_left  = 0;
  int m_idle  = 0;
  int m_ptr   = 0;
  bit m_to    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int wt(input int k);
    return int'(bus.i_weight[k*WW +: WW]);
  endfunction

  // Reference behaviour, advanced once per rising edge from the inputs held over the cycle.
  always @(posedge clk) begin
    bit drop, fin, expd;
    int k;
    if (i_rst) begin
      m_owner = -1; m_ptr = 0; m_to = 1'b0; m_left = 0; m_idle = 0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int off = 0; off < 4; off++) begin
          k = (m_ptr + off) % 4;
          if (m_owner < 0 && bus.i_req[k]) m_owner = k;
        end
        if (m_owner >= 0) begin
          m_ptr  = (m_owner + 1) % 4;
          m_left = (wt(m_owner) == 0) ? 1 : wt(m_owner);
          m_idle = 0;
        end
      end else begin
        drop = !bus.i_req[m_owner];
        fin  = bus.i_beat && (m_left == 1);
        expd = !bus.i_beat && (m_idle + 1 >= TIMEOUT);
        if (drop || fin || expd) begin
          m_owner = -1;
          m_to    = expd && !drop;
        end else if (bus.i_beat) begin
          m_left = m_left - 1;
          m_idle = 0;
        end else begin
          m_idle = m_idle + 1;
        end
      end
    end
  end

  // Every cycle, compare registered outputs to the model half a cycle after the edge.
  always @(negedge clk) begin
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk("model_grant", 32'(bus.o_grant), 32'(eg));
    chk("model_timeout", 32'(bus.o_timeout), 32'(m_to));
    if (m_owner >= 0) chk("model_grant_id", 32'(bus.o_grant_id), 32'(m_owner));
  end

  task automatic tick_expect(input string name, input logic [3:0] g, input logic to);
    @(negedge clk);
    chk(name, 32'(bus.o_grant), 32'(g));
    chk({name, "_to"}, 32'(bus.o_timeout), 32'(to));
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
  endtask

  logic [3:0] seq28 [8];
  logic [3:0] seq29 [5];

  initial begin
    int mode;
    seq28 = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    seq29 = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};

    // Reset held two cycles with all requesting; first grant after release is requester 0.
    i_rst = 1'b1; bus.i_req = 4'hF; bus.i_weight = 16'h1111; bus.i_beat = 1'b0;
    tick_expect("rst_c1", 4'b0000, 1'b0);
    chk("rst_id", 32'(bus.o_grant_id), 32'd0);
    tick_expect("rst_c2", 4'b0000, 1'b0);
    i_rst = 1'b0;
    tick_expect("first_grant", 4'b0001, 1'b0);

    // Unit weights with constant beats rotate through all four with a gap between bursts.
    bus.i_beat = 1'b1;
    for (int i = 0; i < 8; i++) tick_expect($sformatf("rr_seq%0d", i), seq28[i], 1'b0);

    // Weight 3 burst on a lone requester, then a turnaround cycle, then regrant.
    do_reset();
    bus.i_req = 4'b0001; bus.i_weight = 16'h0003; bus.i_beat = 1'b1;
    for (int i = 0; i < 5; i++) tick_expect($sformatf("w3_seq%0d", i), seq29[i], 1'b0);

    // Idle owner 1 held for 16 cycles, forced release pulse, then requester 2 wins.
    do_reset();
    bus.i_req = 4'b0010; bus.i_weight = 16'h1111; bus.i_beat = 1'b0;
    tick_expect("to_grant", 4'b0010, 1'b0);
    bus.i_req = 4'hF;
    for (int i = 1; i < 16; i++) tick_expect($sformatf("to_hold%0d", i), 4'b0010, 1'b0);
    tick_expect("to_release", 4'b0000, 1'b1);
    tick_expect("to_next", 4'b0100, 1'b0);

    // Owner 2 drops its request after two beats; no timeout, pointer now at 3.
    do_reset();
    bus.i_req = 4'b0100; bus.i_weight = 16'h0400; bus.i_beat = 1'b1;
    tick_expect("drop_g1", 4'b0100, 1'b0);
    tick_expect("drop_g2", 4'b0100, 1'b0);
    bus.i_req = 4'b1011; bus.i_beat = 1'b0;
    tick_expect("drop_rel", 4'b0000, 1'b0);
    tick_expect("drop_ptr3", 4'b1000, 1'b0);

    // Reset mid-burst on owner 3 kills the grant; search restarts at 0.
    do_reset();
    bus.i_req = 4'b1000; bus.i_weight = 16'h8000; bus.i_beat = 1'b1;
    tick_expect("mid_g1", 4'b1000, 1'b0);
    tick_expect("mid_g2", 4'b1000, 1'b0);
    i_rst = 1'b1; bus.i_req = 4'hF;
    tick_expect("mid_rst", 4'b0000, 1'b0);
    i_rst = 1'b0;
    tick_expect("mid_regrant", 4'b0001, 1'b0);

    // Randomized traffic in segments: churning requests, idle owners, busy owners.
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) mode = $urandom_range(0, 2);
      i_rst = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < 4; k++) bus.i_weight[k*WW +: WW] = WW'($urandom_range(0, 5));
      case (mode)
        0: begin
          bus.i_req  = 4'($urandom);
          bus.i_beat = $urandom_range(0, 1) == 1;
        end
        1: begin
          if ($urandom_range(0, 59) == 0) bus.i_req = 4'($urandom);
          bus.i_beat = $urandom_range(0, 19) == 0;
        end
        default: begin
          if ($urandom_range(0, 19) == 0) bus.i_req = 4'($urandom);
          bus.i_beat = $urandom_range(0, 9) != 0;
        end
      endcase
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/wrr_burst_scheduler.md
WRR_BURST_SCHEDULER -- requirements
Module: wrr_burst_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning the number of consecutive idle-owner cycles before a forced release (legal range 2..255).
REQ-002 The block SHALL have parameter WW, default 4, meaning the per-requester weight width in bits.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_req  input  4  request per requester; bit k high means requester k wants the shared resource.
REQ-006 i_weight  input  4*WW  burst weight per requester; requester k uses bits [k*WW +: WW].
REQ-007 i_beat  input  1  the current owner completed one transfer this cycle.
REQ-008 o_grant  output  4  registered one-hot grant, or all zero.
REQ-009 o_grant_id  output  2  registered index of the current owner, valid only while o_grant is non-zero.
REQ-010 o_timeout  output  1  registered one-cycle pulse marking a forced release.

Function
REQ-011 The block SHALL implement a two-state FSM, IDLE and ACTIVE; o_grant SHALL be 0 in IDLE and one-hot in ACTIVE.
REQ-012 IDLE with i_req != 0: on the next edge, grant the first set bit searching ptr, ptr+1, ... modulo 4, and enter ACTIVE (grant latency 1 cycle).
REQ-013 IDLE with i_req == 0: remain in IDLE, with ptr and outputs unchanged.
REQ-014 At grant to requester k: ptr <= (k+1) mod 4, credit <= i_weight[k], timer <= 0.
REQ-015 At grant, a weight of 0 SHALL load credit 1; weight changes during ACTIVE SHALL be ignored.
REQ-016 In ACTIVE with i_beat=1 and credit == 1, the block SHALL release, entering IDLE on the next edge.
REQ-017 In ACTIVE with i_beat=1 and credit > 1, the block SHALL decrement credit and clear timer.
REQ-018 In ACTIVE with i_beat=0, timer SHALL increment.
REQ-019 In ACTIVE with i_beat=0 and timer == TIMEOUT-1, the block SHALL release and set o_timeout=1 for exactly the first IDLE cycle.
REQ-020 In ACTIVE with i_req[owner]==0, the block SHALL release regardless of credit or timer; no o_timeout pulse; a same-cycle beat is counted but irrelevant.
REQ-021 Simultaneous release causes SHALL all produce one release; o_timeout SHALL be asserted only when timeout is the sole cause.
REQ-022 Every release SHALL be followed by at least one IDLE cycle with o_grant=0 (bus turnaround); arbitration occurs in that cycle.
REQ-023 Requests from non-owners during ACTIVE SHALL not affect the grant; no preemption.
REQ-024 credit SHALL be WW bits wide and timer SHALL be ceil(log2(TIMEOUT)) bits wide; neither SHALL wrap in legal operation.

Reset
REQ-025 While i_rst=1 at an edge: state=IDLE, o_grant=0, o_grant_id=0, o_timeout=0, ptr=0, credit=0, timer=0.
REQ-026 Reset SHALL override all other inputs, including mid-burst; the first grant after reset SHALL search from requester 0.

Verification
REQ-027 The bench SHALL cover: i_rst=1 for 2 cycles with i_req=4'hF -> o_grant=0 throughout; after release, the first grant is 4'b0001 one cycle later.
REQ-028 The bench SHALL cover: i_req=4'hF, all weights 1, i_beat=1 constant -> o_grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-029 The bench SHALL cover: i_req=4'b0001, weight0=3, i_beat=1 constant -> o_grant=0001 for 3 cycles, 0000 for 1 cycle, then 0001 again.
REQ-030 The bench SHALL cover: grant to requester 1, i_beat=0, TIMEOUT=16 -> o_grant=0010 for 16 cycles, then o_grant=0 with o_timeout=1 for one cycle, and the next requester is granted.
REQ-031 The bench SHALL cover: weight2=4, i_req[2] dropped after 2 beats -> o_grant=0 on the next edge, o_timeout=0, ptr=3.
REQ-032 The bench SHALL cover: i_rst=1 pulsed mid-burst on owner 3 -> o_grant=0 on the next edge; with i_req=4'hF, the next grant is 0001.
